// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Holds the arbiter state encoding, the burst tag nibble and the source-count limit.
package uart_arb_pkg;

   // IDLE searches for work, HDR sends the tag byte, RD/CAP/SEND move one data byte.
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      RD,
      CAP,
      SEND
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;
   localparam int         MAX_SRC = 8;
   localparam int         IDX_W   = $clog2(MAX_SRC);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Valid/ready byte link between the arbiter and the UART TX core.
// The arbiter is the master: it presents a byte and holds it until the UART takes it.
interface uart_tx_arbiter_if;

   logic [7:0] uart_data;
   logic       uart_valid;
   logic       uart_ready;

   modport master (output uart_data, output uart_valid, input  uart_ready);
   modport slave  (input  uart_data, input  uart_valid, output uart_ready);

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first eligible index after 'last'.
// The most recently served index is checked last, so it has the lowest priority.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int N_SRC = 2
) (
   input  logic [N_SRC-1:0] eligible,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] nextIdx
);

   // Walk the candidates in order last+1, last+2, ... wrapping at N_SRC and stop at
   // the first eligible one. Both loops have constant bounds so this unrolls into
   // a small priority mux rather than any sequential search.
   always_comb begin
      found   = 1'b0;
      nextIdx = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (!found && eligible[i] && (i == ((int'(last) + k) % N_SRC))) begin
               found   = 1'b1;
               nextIdx = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter draining up to BURST_LEN bytes per grant from source FIFOs into one UART TX.
// Define UART_ARB_HEADER_EN to prefix every burst with the tag byte {4'hA, 1'b0, grant_id}.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_SRC     = 2,
   parameter int BURST_LEN = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SRC*8-1:0] src_dout,
   input  logic [N_SRC-1:0]   src_empty,
   input  logic [N_SRC-1:0]   src_enable,
   output logic [N_SRC-1:0]   src_rd_en,
   uart_tx_arbiter_if.master  uart,
   output logic               busy,
   output logic [IDX_W-1:0]   grant_id
);

   arb_state_t       state;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] last;
   logic [7:0]       count;
   logic [7:0]       dataReg;
   logic             validReg;
   logic [N_SRC-1:0] rdEnReg;

   logic [N_SRC-1:0] eligible;
   logic             pickFound;
   logic [IDX_W-1:0] pickIdx;
   logic [7:0]       grantByte;
   logic             grantEmpty;

   function automatic logic [N_SRC-1:0] oneHot(input logic [IDX_W-1:0] idx);
      oneHot = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (idx == IDX_W'(i)) oneHot[i] = 1'b1;
      end
   endfunction

   assign eligible = src_enable & ~src_empty;

   rr_picker #(
      .N_SRC (N_SRC)
   ) picker (
      .eligible (eligible),
      .last     (last),
      .found    (pickFound),
      .nextIdx  (pickIdx)
   );

   // Select the granted source's read data and empty flag. Constant-index loops keep
   // the mux free of out-of-range selects when N_SRC is not a power of two.
   always_comb begin
      grantByte  = '0;
      grantEmpty = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant == IDX_W'(i)) begin
            grantByte  = src_dout[8*i +: 8];
            grantEmpty = src_empty[i];
         end
      end
   end

   // Main arbiter FSM. The read strobe and valid flag are registered alongside the
   // state transition that enters RD or HDR/SEND, so they are pure functions of the
   // state register and never see a combinational path from any input. The burst
   // count is only compared at a SEND transfer, and an early-empty source ends the
   // burst there too, so RD is only ever entered for a FIFO known to hold data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         last     <= IDX_W'(N_SRC - 1);
         count    <= '0;
         dataReg  <= '0;
         validReg <= 1'b0;
         rdEnReg  <= '0;
      end else begin
         rdEnReg <= '0;
         unique case (state)
            IDLE: begin
               if (pickFound) begin
                  grant <= pickIdx;
                  count <= '0;
`ifdef UART_ARB_HEADER_EN
                  state    <= HDR;
                  dataReg  <= {HDR_TAG, 1'b0, pickIdx};
                  validReg <= 1'b1;
`else
                  state   <= RD;
                  rdEnReg <= oneHot(pickIdx);
`endif
               end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: begin
               if (uart.uart_ready) begin
                  state    <= RD;
                  validReg <= 1'b0;
                  rdEnReg  <= oneHot(grant);
               end
            end
`endif
            RD: begin
               state <= CAP;
            end
            CAP: begin
               state    <= SEND;
               dataReg  <= grantByte;
               validReg <= 1'b1;
            end
            SEND: begin
               if (uart.uart_ready) begin
                  validReg <= 1'b0;
                  count    <= count + 8'd1;
                  if ((count + 8'd1) == 8'(BURST_LEN) || grantEmpty) begin
                     state <= IDLE;
                     last  <= grant;
                  end else begin
                     state   <= RD;
                     rdEnReg <= oneHot(grant);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               validReg <= 1'b0;
            end
         endcase
      end
   end

   assign src_rd_en       = rdEnReg;
   assign uart.uart_data  = dataReg;
   assign uart.uart_valid = validReg;
   assign busy            = (state != IDLE);
   assign grant_id        = grant;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler sharing the single UART transmitter between N_SRC byte-FIFO producers (e.g. convolution result stream, debug/status stream). Each grant drains up to BURST_LEN bytes from one source FIFO and forwards them over a valid/ready byte interface to the UART TX. An optional tag byte is sent before every burst. The block sits between the source FIFOs and the UART TX core, replacing any single-source FIFO-to-UART glue.

## Interface
- N_SRC, 2, number of sources; legal range 1..8.
- BURST_LEN, 16, maximum bytes per grant; legal range 1..255.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- src_dout  in  N_SRC*8  FIFO read data; source i occupies bits [8i+7:8i]. Valid one cycle after that source's rd_en.
- src_empty  in  N_SRC  FIFO empty flags.
- src_enable  in  N_SRC  per-source arbitration mask; a 0 bit excludes that source from new grants.
- src_rd_en  out  N_SRC  one-hot FIFO read strobe, one cycle per byte.
- uart_data  out  8  byte to the UART.
- uart_valid  out  1  byte valid; held until accepted.
- uart_ready  in  1  UART can accept a byte; a transfer occurs on a cycle where uart_valid and uart_ready are both 1.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  3  index of the current or last granted source.

## Operation
- States: IDLE, HDR, RD, CAP, SEND.
- IDLE: a source is eligible when its src_enable is 1 and its src_empty is 0.
  - Search order is last+1, last+2, … with wrap at N_SRC, so the most recently served source has the lowest priority.
  - If any source is eligible: latch it as grant, clear the byte count, go to HDR if headers are compiled in, else go to RD.
  - If none is eligible: stay in IDLE.
- HDR: uart_data = 8'hA0 | grant_id. uart_valid = 1. On a transfer, go to RD.
- RD: src_rd_en[grant] = 1 for this cycle only. Go to CAP.
- CAP: capture src_dout[grant] into uart_data. Go to SEND.
- SEND: uart_valid = 1 and uart_data is held stable until a transfer. On the transfer cycle:
  - count increments;
  - if count reaches BURST_LEN, or src_empty[grant] is 1, go to IDLE and set last = grant;
  - otherwise go to RD.
- src_enable is sampled only in IDLE. Clearing a source's enable mid-burst does not shorten the current burst.
- src_rd_en and uart_valid are decodes of the state register only; they do not depend combinationally on any input.
- Count register is 8 bits; BURST_LEN ≤ 255 guarantees it cannot wrap.
- The block never reads an empty FIFO: RD is entered only after a non-empty check (in IDLE or at the SEND transfer).

## Timing
- Reset values: state = IDLE, last = N_SRC-1 (source 0 is served first), src_rd_en = 0, uart_valid = 0, uart_data = 8'h00, busy = 0, grant_id = 0.
- First-byte latency, with a source non-empty in IDLE at cycle n:
  - headers out: src_rd_en at n+1, uart_valid at n+3;
  - headers in: header valid at n+1; if ready is held high, rd_en at n+2 and data valid at n+4.
- Inter-byte spacing with uart_ready held high: 3 cycles per byte (RD, CAP, SEND).
- Back-to-back grants: one IDLE cycle between the last data transfer of one burst and the next grant.
- uart_ready low while uart_valid is high: uart_valid and uart_data are held indefinitely.
- rst asserted mid-burst: return to IDLE on the next edge. A byte already read from the FIFO but not yet transferred is discarded. No partial-burst recovery.
- Source goes empty during the burst: detected at the SEND transfer; the burst ends early and no header-only burst occurs.

## Configuration
- UART_ARB_HEADER_EN defined: HDR state exists and every burst is prefixed with tag byte {4'hA, 1'b0, grant_id}.
- UART_ARB_HEADER_EN undefined: HDR state is removed, IDLE goes directly to RD, and the output is the raw byte stream only.

## Structure
- Package uart_arb_pkg holds:
  - state enum arb_state_t;
  - HDR_TAG = 4'hA;
  - MAX_SRC = 8.
- Sub-module rr_picker (combinational): inputs are the eligible mask and last; outputs are a found flag and the next index. It is instantiated once and reused for future arbiters.

## Test plan
- Reset, then source 0 holds 3 bytes {11,22,33}, headers on, ready held high → UART receives A0,11,22,33; src_rd_en pulses exactly 3 times; busy drops after the last transfer.
- Both sources hold 40 bytes, BURST_LEN=16 → byte stream order is A0+16 bytes from source 0, A1+16 from source 1, A0+16 from source 0, A1+16 from source 1, A0+8 from source 0, A1+8 from source 1.
- uart_ready low for 10 cycles while uart_valid is high → uart_data is stable and no extra src_rd_en pulses occur.
- src_enable = 2'b10 with both sources non-empty → only source 1 is granted; grant_id = 1.
- rst pulsed for one cycle in the CAP state → next cycle is IDLE with uart_valid = 0; the next burst starts at source 0.
- Headers compiled out, single byte 5A → uart_valid asserts exactly 3 cycles after the source goes non-empty, carrying 5A.
